// File: rtl/tt_ctrl_sel_if.sv
// Pad-side control inputs and mux-spine outputs of the design-select controller.
// master drives the raw pads and observes the spine; slave is the controller.
interface tt_ctrl_sel_if #(
    parameter int N_ADDR_BITS = 10
);
    logic                   ctrl_ena_in;
    logic                   ctrl_inc_in;
    logic                   ctrl_rst_n_in;
    logic [N_ADDR_BITS-1:0] sel_addr;
    logic                   sel_valid;
    logic                   ena_out;
    logic                   ovf;

    modport master (
        output ctrl_ena_in, ctrl_inc_in, ctrl_rst_n_in,
        input  sel_addr, sel_valid, ena_out, ovf
    );

    modport slave (
        input  ctrl_ena_in, ctrl_inc_in, ctrl_rst_n_in,
        output sel_addr, sel_valid, ena_out, ovf
    );
endinterface

// File: rtl/tt_ctrl_sel.sv
// Design-select controller: synchronises and debounces the ctrl pads, counts
// filtered inc rising edges into a design address and gates the design enable.
module tt_ctrl_sel #(
    parameter int N_ADDR_BITS = 10,
    parameter int MAX_ADDR    = 1023,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4
) (
    input  logic         clk,
    input  logic         rst,
    tt_ctrl_sel_if.slave bus
);

    localparam int IN_ENA  = 0;
    localparam int IN_INC  = 1;
    localparam int IN_RSTN = 2;
    localparam int CNT_W   = $clog2(DEBOUNCE + 1);

    localparam logic [CNT_W-1:0]       CNT_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [N_ADDR_BITS-1:0] ADDR_MAX = N_ADDR_BITS'(MAX_ADDR);

    generate
        if (MAX_ADDR < 0 || MAX_ADDR >= (1 << N_ADDR_BITS)) begin : g_bad_max_addr
            $error("tt_ctrl_sel: MAX_ADDR does not fit in N_ADDR_BITS");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("tt_ctrl_sel: SYNC_STAGES must be at least 2");
        end
        if (DEBOUNCE < 1) begin : g_bad_debounce
            $error("tt_ctrl_sel: DEBOUNCE must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_RESET  = 2'd0,
        S_IDLE   = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    // Wrapping address step; the flag reports that the step wrapped to zero.
    function automatic logic [N_ADDR_BITS:0] addr_step(input logic [N_ADDR_BITS-1:0] a);
        if (a == ADDR_MAX) begin
            return {1'b1, {N_ADDR_BITS{1'b0}}};
        end
        return {1'b0, a + N_ADDR_BITS'(1)};
    endfunction

    logic [2:0]             w_raw;
    logic                   w_inc_rise;
    logic [N_ADDR_BITS:0]   w_step;
    logic [SYNC_STAGES-1:0] r_sync [3];
    logic [CNT_W-1:0]       r_cnt  [3];
    logic [2:0]             r_filt;
    logic                   r_filt_inc_d;
    state_t                 r_state;
    logic [N_ADDR_BITS-1:0] r_addr;
    logic                   r_valid;
    logic                   r_ena;
    logic                   r_ovf;

    assign w_raw      = {bus.ctrl_rst_n_in, bus.ctrl_inc_in, bus.ctrl_ena_in};
    assign w_inc_rise = r_filt[IN_INC] & ~r_filt_inc_d;
    assign w_step     = addr_step(r_addr);

    // Stage 1: synchronisers and per-input debounce filters
    always_ff @(posedge clk) begin : p_filter
        if (rst) begin
            for (int k = 0; k < 3; k++) begin
                r_sync[k] <= '0;
                r_cnt[k]  <= '0;
            end
            r_filt       <= '0;
            r_filt_inc_d <= 1'b0;
        end else begin
            r_filt_inc_d <= r_filt[IN_INC];
            for (int k = 0; k < 3; k++) begin
                r_sync[k] <= {r_sync[k][SYNC_STAGES-2:0], w_raw[k]};
                if (r_sync[k][SYNC_STAGES-1] == r_filt[k]) begin
                    r_cnt[k] <= '0;
                end else if (r_cnt[k] == CNT_LAST) begin
                    r_cnt[k]  <= '0;
                    r_filt[k] <= ~r_filt[k];
                end else begin
                    r_cnt[k] <= r_cnt[k] + CNT_W'(1);
                end
            end
        end
    end

    // Stage 2: selection FSM on the filtered levels; selection reset has top priority
    always_ff @(posedge clk) begin : p_fsm
        if (rst || !r_filt[IN_RSTN]) begin
            r_state <= S_RESET;
            r_addr  <= '0;
            r_valid <= 1'b0;
            r_ena   <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            case (r_state)
                S_RESET: begin
                    r_state <= S_IDLE;
                    r_valid <= 1'b1;
                end
                S_IDLE: begin
                    if (r_filt[IN_ENA]) begin
                        r_state <= S_ACTIVE;
                        r_ena   <= 1'b1;
                    end else if (w_inc_rise) begin
                        r_addr <= w_step[N_ADDR_BITS-1:0];
                        if (w_step[N_ADDR_BITS]) begin
                            r_ovf <= 1'b1;
                        end
                    end
                end
                S_ACTIVE: begin
                    if (!r_filt[IN_ENA]) begin
                        r_state <= S_IDLE;
                        r_ena   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_RESET;
                    r_addr  <= '0;
                    r_valid <= 1'b0;
                    r_ena   <= 1'b0;
                    r_ovf   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel_addr  = r_addr;
    assign bus.sel_valid = r_valid;
    assign bus.ena_out   = r_ena;
    assign bus.ovf       = r_ovf;

endmodule

// File: tb/tb_tt_ctrl_sel.sv
// Scoreboard bench for tt_ctrl_sel: a reference model predicts every output change
// with its clock edge; an independent monitor compares each change the DUT makes.
`timescale 1ns/1ps
module tb_tt_ctrl_sel;

    localparam int N_ADDR_BITS = 4;
    localparam int MAX_ADDR    = 9;
    localparam int SYNC_STAGES = 2;
    localparam int DEBOUNCE    = 4;
    localparam int MAXC        = 20000;

    localparam int MODE_RESET  = 0;
    localparam int MODE_IDLE   = 1;
    localparam int MODE_ACTIVE = 2;

    typedef struct packed {
        logic [N_ADDR_BITS-1:0] addr;
        logic                   valid;
        logic                   ena;
        logic                   ovf;
    } outs_t;

    typedef struct {
        int    edge_no;
        outs_t o;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];

    tt_ctrl_sel_if #(.N_ADDR_BITS(N_ADDR_BITS)) bus ();

    tt_ctrl_sel #(
        .N_ADDR_BITS(N_ADDR_BITS),
        .MAX_ADDR   (MAX_ADDR),
        .SYNC_STAGES(SYNC_STAGES),
        .DEBOUNCE   (DEBOUNCE)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state: raw sample history per pad, filtered levels, selection mode.
    bit    hist [3][MAXC];
    bit    m_filt [3];
    bit    m_inc_prev;
    int    m_last_rst = 0;
    int    m_mode = MODE_RESET;
    int    m_addr = 0;
    bit    m_ena = 1'b0;
    bit    m_ovf = 1'b0;
    outs_t m_last = '0;

    function automatic outs_t cur_outs();
        outs_t o;
        o.addr  = bus.sel_addr;
        o.valid = bus.sel_valid;
        o.ena   = bus.ena_out;
        o.ovf   = bus.ovf;
        return o;
    endfunction

    // Predicts outputs after edge t. A pad level is accepted once the last DEBOUNCE
    // synchronised samples (all taken after the last reset) differ from the accepted level.
    function automatic void model_step(int t, bit r, bit [2:0] raw);
        outs_t now;
        bit    rise;
        bit    moved;
        if (r) begin
            for (int j = t - SYNC_STAGES + 1; j <= t; j++) begin
                if (j >= 0) for (int k = 0; k < 3; k++) hist[k][j] = 1'b0;
            end
            for (int k = 0; k < 3; k++) m_filt[k] = 1'b0;
            m_inc_prev = 1'b0;
            m_last_rst = t;
            m_mode     = MODE_RESET;
            m_addr     = 0;
            m_ena      = 1'b0;
            m_ovf      = 1'b0;
        end else begin
            for (int k = 0; k < 3; k++) hist[k][t] = raw[k];
            rise = m_filt[1] && !m_inc_prev;
            if (!m_filt[2]) begin
                m_mode = MODE_RESET;
                m_addr = 0;
                m_ovf  = 1'b0;
                m_ena  = 1'b0;
            end else if (m_mode == MODE_RESET) begin
                m_mode = MODE_IDLE;
            end else if (m_mode == MODE_IDLE) begin
                if (m_filt[0]) begin
                    m_mode = MODE_ACTIVE;
                    m_ena  = 1'b1;
                end else if (rise) begin
                    m_addr = (m_addr + 1) % (MAX_ADDR + 1);
                    if (m_addr == 0) m_ovf = 1'b1;
                end
            end else if (!m_filt[0]) begin
                m_mode = MODE_IDLE;
                m_ena  = 1'b0;
            end
            m_inc_prev = m_filt[1];
            if (t - DEBOUNCE + 1 > m_last_rst) begin
                for (int k = 0; k < 3; k++) begin
                    moved = 1'b1;
                    for (int j = t - SYNC_STAGES - DEBOUNCE + 1; j <= t - SYNC_STAGES; j++) begin
                        if (hist[k][j] == m_filt[k]) moved = 1'b0;
                    end
                    if (moved) m_filt[k] = !m_filt[k];
                end
            end
        end
        now.addr  = N_ADDR_BITS'(m_addr);
        now.valid = (m_mode != MODE_RESET);
        now.ena   = m_ena;
        now.ovf   = m_ovf;
        if (now != m_last) begin
            sb_q.push_back('{edge_no: t, o: now});
            m_last = now;
        end
    endfunction

    // Advance n cycles; every edge is predicted as it is issued.
    task automatic run(int n);
        for (int c = 0; c < n; c++) begin
            if (cyc + 1 < MAXC) begin
                model_step(cyc + 1, rst, {bus.ctrl_rst_n_in, bus.ctrl_inc_in, bus.ctrl_ena_in});
            end
            @(negedge clk);
        end
    endtask

    task automatic pads(bit e, bit i, bit r);
        bus.ctrl_ena_in   = e;
        bus.ctrl_inc_in   = i;
        bus.ctrl_rst_n_in = r;
    endtask

    task automatic pulse(int hi, int lo);
        bus.ctrl_inc_in = 1'b1;
        run(hi);
        bus.ctrl_inc_in = 1'b0;
        run(lo);
    endtask

    task automatic check_now(string name, outs_t req);
        outs_t cur;
        cur = cur_outs();
        checks++;
        if (cur !== req) begin
            errors++;
            $display("FAIL %s: got addr=%0d valid=%0b ena=%0b ovf=%0b, required addr=%0d valid=%0b ena=%0b ovf=%0b",
                     name, cur.addr, cur.valid, cur.ena, cur.ovf, req.addr, req.valid, req.ena, req.ovf);
        end
    endtask

    function automatic outs_t mk(int a, bit v, bit e, bit o);
        outs_t r;
        r.addr  = N_ADDR_BITS'(a);
        r.valid = v;
        r.ena   = e;
        r.ovf   = o;
        return r;
    endfunction

    // Monitor: every output change must match the next predicted change, at the same edge.
    initial begin : monitor
        outs_t mon_last;
        outs_t cur;
        exp_t  e;
        mon_last = '0;
        forever begin
            @(negedge clk);
            cur = cur_outs();
            if (cyc >= 1 && cur !== mon_last) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: edge %0d got addr=%0d valid=%0b ena=%0b ovf=%0b, required no change",
                             cyc, cur.addr, cur.valid, cur.ena, cur.ovf);
                end else begin
                    e = sb_q.pop_front();
                    if (e.edge_no != cyc || e.o !== cur) begin
                        errors++;
                        $display("FAIL sb_change: got addr=%0d valid=%0b ena=%0b ovf=%0b at edge %0d, required addr=%0d valid=%0b ena=%0b ovf=%0b at edge %0d",
                                 cur.addr, cur.valid, cur.ena, cur.ovf, cyc,
                                 e.o.addr, e.o.valid, e.o.ena, e.o.ovf, e.edge_no);
                    end
                end
                mon_last = cur;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst = 1'b1;
        pads(1'b1, 1'b1, 1'b1);
        run(3);
        check_now("reset_state", mk(0, 0, 0, 0));

        // Release: selection becomes valid on the 7th edge, then ena goes active.
        rst = 1'b0;
        run(6);
        check_now("valid_not_before_7", mk(0, 0, 0, 0));
        run(1);
        check_now("valid_at_edge_7", mk(0, 1, 0, 0));
        run(6);
        pads(1'b0, 1'b0, 1'b1);
        run(12);

        // Clean increments.
        for (int p = 0; p < 3; p++) pulse(8, 8);
        check_now("three_increments", mk(3, 1, 0, 0));

        // Glitches shorter than the debounce window are rejected.
        pulse(3, 1);
        pulse(3, 8);
        check_now("glitch_rejected", mk(3, 1, 0, 0));
        pulse(4, 8);
        check_now("four_cycle_inc", mk(4, 1, 0, 0));

        // Wrap and sticky overflow, cleared by selection reset.
        bus.ctrl_rst_n_in = 1'b0;
        run(8);
        check_now("sel_reset", mk(0, 0, 0, 0));
        bus.ctrl_rst_n_in = 1'b1;
        run(8);
        for (int p = 0; p < 9; p++) pulse(8, 8);
        check_now("addr_max", mk(9, 1, 0, 0));
        pulse(8, 8);
        check_now("wrap_ovf", mk(0, 1, 0, 1));
        pulse(8, 8);
        check_now("ovf_sticky", mk(1, 1, 0, 1));
        bus.ctrl_rst_n_in = 1'b0;
        run(8);
        check_now("ovf_cleared", mk(0, 0, 0, 0));
        bus.ctrl_rst_n_in = 1'b1;
        run(8);

        // Enable gating: increments discarded while active.
        for (int p = 0; p < 5; p++) pulse(8, 8);
        bus.ctrl_ena_in = 1'b1;
        run(10);
        check_now("active_addr5", mk(5, 1, 1, 0));
        pulse(8, 8);
        pulse(8, 8);
        check_now("inc_frozen", mk(5, 1, 1, 0));
        bus.ctrl_ena_in = 1'b0;
        run(10);
        pulse(8, 8);
        check_now("inc_after_idle", mk(6, 1, 0, 0));

        // Selection reset and inc change together while active: reset wins.
        bus.ctrl_rst_n_in = 1'b0;
        run(8);
        bus.ctrl_rst_n_in = 1'b1;
        run(8);
        for (int p = 0; p < 5; p++) pulse(8, 8);
        bus.ctrl_ena_in = 1'b1;
        run(10);
        pads(1'b1, 1'b1, 1'b0);
        run(10);
        check_now("reset_beats_inc", mk(0, 0, 0, 0));
        pads(1'b0, 1'b0, 1'b1);
        run(14);
        pulse(8, 8);
        bus.ctrl_inc_in = 1'b1;
        run(3);
        rst = 1'b1;
        run(1);
        check_now("rst_mid_debounce", mk(0, 0, 0, 0));
        rst = 1'b0;
        bus.ctrl_inc_in = 1'b0;
        run(14);

        // Randomised pad activity, including glitches and core resets.
        for (int s = 0; s < 300; s++) begin
            if ($urandom_range(0, 3) == 0) bus.ctrl_ena_in = ~bus.ctrl_ena_in;
            if ($urandom_range(0, 1) == 0) bus.ctrl_inc_in = ~bus.ctrl_inc_in;
            bus.ctrl_rst_n_in = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) begin
                rst = 1'b1;
                run($urandom_range(1, 2));
                rst = 1'b0;
            end
            run($urandom_range(1, 9));
        end

        pads(1'b0, 1'b0, 1'b1);
        run(20);
        while (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            checks++;
            errors++;
            $display("FAIL sb_missing: got no change, required addr=%0d valid=%0b ena=%0b ovf=%0b at edge %0d",
                     e.o.addr, e.o.valid, e.o.ena, e.o.ovf, e.edge_no);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
